// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Bursts of up to MAX_BURST words per grant; FIFO occupancy is mirrored locally.

module fifo_write_arbiter_lane #(
    parameter int DW = 16
) (
    input  logic          sel_i,
    input  logic          busy_i,
    input  logic          full_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          hs_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);
    // Ready is a function of registered state only, never of valid.
    assign ready_o = sel_i & busy_i & ~full_i;
    assign hs_o    = ready_o & valid_i;
    assign valid_o = sel_i & valid_i;
    assign data_o  = data_i & {DW{sel_i}};
endmodule

module fifo_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_ENTRIES = 16,
    parameter int MAX_BURST    = 4,
    localparam int GW = $clog2(NUM_REQ),
    localparam int CW = $clog2(FIFO_ENTRIES + 1)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_d_in,
    input  logic                          fifo_r_en,
    output logic [CW-1:0]                 fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id
);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [CW-1:0]   count_q, count_d;

    logic [NUM_REQ-1:0]                 lane_sel, lane_hs, lane_vld;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
    logic                               full, hs, valid_g, rd;
    logic                               pick_vld;
    logic [GW-1:0]                      pick;

    assign full = (count_q == CW'(FIFO_ENTRIES));

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        assign lane_sel[g] = (grant_q == GW'(g));
        fifo_write_arbiter_lane #(.DW(DATA_WIDTH)) u_lane (
            .sel_i   (lane_sel[g]),
            .busy_i  (state_q == GRANT),
            .full_i  (full),
            .valid_i (req_valid[g]),
            .data_i  (req_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .ready_o (req_ready[g]),
            .hs_o    (lane_hs[g]),
            .valid_o (lane_vld[g]),
            .data_o  (lane_data[g])
        );
    end

    assign hs      = |lane_hs;
    assign valid_g = |lane_vld;

    always_comb begin
        fifo_d_in = '0;
        for (int i = 0; i < NUM_REQ; i++) fifo_d_in = fifo_d_in | lane_data[i];
    end

    // Scan from farthest to nearest so the first requester after last_q wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = last_q;
        for (int off = NUM_REQ; off >= 1; off--) begin
            if (req_valid[GW'((int'(last_q) + off) % NUM_REQ)]) begin
                pick_vld = 1'b1;
                pick     = GW'((int'(last_q) + off) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    grant_d = pick;
                    last_d  = pick;
                    burst_d = '0;
                end
            end
            GRANT: begin
                // A full stall holds the grant unless the producer withdraws.
                if (!valid_g) begin
                    state_d = IDLE;
                end else if (hs) begin
                    if (burst_q == BW'(MAX_BURST - 1)) state_d = IDLE;
                    else                               burst_d = burst_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reads of an empty FIFO are ignored, matching the FIFO's own behaviour.
    assign rd = fifo_r_en && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (hs && !rd)      count_d = count_q + CW'(1);
        else if (!hs && rd) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            burst_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            count_q <= count_d;
        end
    end

    assign fifo_w_en  = hs;
    assign fifo_count = count_q;
    assign fifo_full  = full;
    assign fifo_empty = (count_q == '0);
    assign busy       = (state_q == GRANT);
    assign grant_id   = grant_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: vector table plus hand-written corner sequences.
module tb_fifo_write_arbiter;
    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_w_en;
    logic [15:0] fifo_d_in;
    logic        fifo_r_en;
    logic [4:0]  fifo_count;
    logic        fifo_full, fifo_empty, busy;
    logic [1:0]  grant_id;

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .FIFO_ENTRIES(16), .MAX_BURST(4)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_w_en(fifo_w_en), .fifo_d_in(fifo_d_in),
        .fifo_r_en(fifo_r_en), .fifo_count(fifo_count), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Inputs and outputs expected in the cycle the inputs are applied.
    typedef struct {
        logic [3:0]  v;
        logic        r;
        logic [11:0] w;
        logic [3:0]  rdy;
        logic        wen;
        logic [15:0] din;
        logic [4:0]  cnt;
        logic        bsy;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl[16];
    vec_t row;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
        end
    endtask

    // Producer i presents {i, w}, so the written word identifies its source.
    task automatic drive(input logic [3:0] v, input logic r, input logic [11:0] w);
        req_valid = v;
        fifo_r_en = r;
        for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = {4'(i), w};
    endtask

    task automatic step(input string tag, input int idx, input vec_t t);
        drive(t.v, t.r, t.w);
        @(negedge clk);
        chk({tag, ".ready"}, idx, 32'(req_ready), 32'(t.rdy));
        chk({tag, ".w_en"},  idx, 32'(fifo_w_en), 32'(t.wen));
        chk({tag, ".d_in"},  idx, 32'(fifo_d_in), 32'(t.din));
        chk({tag, ".count"}, idx, 32'(fifo_count), 32'(t.cnt));
        chk({tag, ".busy"},  idx, 32'(busy), 32'(t.bsy));
        chk({tag, ".gid"},   idx, 32'(grant_id), 32'(t.gid));
        chk({tag, ".full"},  idx, 32'(fifo_full), 32'(t.cnt == 5'd16));
        chk({tag, ".empty"}, idx, 32'(fifo_empty), 32'(t.cnt == 5'd0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(4'h0, 1'b0, 12'h000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                 v       r     w       rdy     wen   din       cnt    bsy   gid
        tbl[0]  = '{4'b0100, 1'b0, 12'h000, 4'b0000, 1'b0, 16'h0000, 5'd0, 1'b0, 2'd0};
        tbl[1]  = '{4'b0100, 1'b0, 12'h000, 4'b0100, 1'b1, 16'h2000, 5'd0, 1'b1, 2'd2};
        tbl[2]  = '{4'b0100, 1'b0, 12'h001, 4'b0100, 1'b1, 16'h2001, 5'd1, 1'b1, 2'd2};
        tbl[3]  = '{4'b0100, 1'b0, 12'h002, 4'b0100, 1'b1, 16'h2002, 5'd2, 1'b1, 2'd2};
        tbl[4]  = '{4'b0100, 1'b0, 12'h003, 4'b0100, 1'b1, 16'h2003, 5'd3, 1'b1, 2'd2};
        tbl[5]  = '{4'b0100, 1'b0, 12'h004, 4'b0000, 1'b0, 16'h2004, 5'd4, 1'b0, 2'd2};
        tbl[6]  = '{4'b0100, 1'b0, 12'h004, 4'b0100, 1'b1, 16'h2004, 5'd4, 1'b1, 2'd2};
        tbl[7]  = '{4'b0100, 1'b0, 12'h005, 4'b0100, 1'b1, 16'h2005, 5'd5, 1'b1, 2'd2};
        tbl[8]  = '{4'b0000, 1'b0, 12'h005, 4'b0100, 1'b0, 16'h2005, 5'd6, 1'b1, 2'd2};
        tbl[9]  = '{4'b0000, 1'b1, 12'h005, 4'b0000, 1'b0, 16'h2005, 5'd6, 1'b0, 2'd2};
        tbl[10] = '{4'b0000, 1'b1, 12'h005, 4'b0000, 1'b0, 16'h2005, 5'd5, 1'b0, 2'd2};
        tbl[11] = '{4'b0010, 1'b1, 12'h010, 4'b0000, 1'b0, 16'h2010, 5'd4, 1'b0, 2'd2};
        tbl[12] = '{4'b0010, 1'b1, 12'h010, 4'b0010, 1'b1, 16'h1010, 5'd3, 1'b1, 2'd1};
        tbl[13] = '{4'b0010, 1'b0, 12'h011, 4'b0010, 1'b1, 16'h1011, 5'd3, 1'b1, 2'd1};
        tbl[14] = '{4'b0000, 1'b0, 12'h011, 4'b0010, 1'b0, 16'h1011, 5'd4, 1'b1, 2'd1};
        tbl[15] = '{4'b0000, 1'b0, 12'h011, 4'b0000, 1'b0, 16'h1011, 5'd4, 1'b0, 2'd1};

        // Outputs while held in reset.
        resetn = 1'b0;
        drive(4'hF, 1'b1, 12'h123);
        #12;
        chk("rst.ready", 0, 32'(req_ready), 32'h0);
        chk("rst.w_en",  0, 32'(fifo_w_en), 32'h0);
        chk("rst.busy",  0, 32'(busy), 32'h0);
        chk("rst.full",  0, 32'(fifo_full), 32'h0);
        chk("rst.empty", 0, 32'(fifo_empty), 32'h1);
        chk("rst.count", 0, 32'(fifo_count), 32'h0);
        chk("rst.d_in",  0, 32'(fifo_d_in), 32'h0123);
        chk("rst.gid",   0, 32'(grant_id), 32'h0);

        // Single producer bursts, then reads and a concurrent read/write.
        do_reset();
        for (int i = 0; i < 16; i++) step("tbl", i, tbl[i]);

        // Reads of an empty FIFO leave the count at zero.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            row = '{4'b0000, 1'b1, 12'h0AB, 4'b0000, 1'b0, 16'h00AB, 5'd0, 1'b0, 2'd0};
            step("empty_rd", i, row);
        end

        // All producers valid: grants 0,1,2,3 with one bubble each, filling the FIFO.
        begin
            int ec = 0;
            for (int c = 0; c <= 20; c++) begin
                logic       b;
                logic [1:0] g;
                b = (c % 5) != 0;
                g = (c == 0) ? 2'd0 : (b ? 2'((c / 5) % 4) : 2'((c / 5 - 1) % 4));
                row = '{4'b1111, 1'b0, 12'h0AB, b ? (4'b0001 << g) : 4'b0000, b,
                        {4'(g), 12'h0AB}, 5'(ec), b, g};
                step("rr", c, row);
                if (b) ec++;
            end
        end

        // FIFO full: grant to 0 is held, single reads let exactly one word through.
        row = '{4'b1111, 1'b0, 12'h0AB, 4'b0000, 1'b0, 16'h00AB, 5'd16, 1'b1, 2'd0}; step("full", 0, row);
        row = '{4'b1111, 1'b0, 12'h0AB, 4'b0000, 1'b0, 16'h00AB, 5'd16, 1'b1, 2'd0}; step("full", 1, row);
        row = '{4'b1111, 1'b1, 12'h0AB, 4'b0000, 1'b0, 16'h00AB, 5'd16, 1'b1, 2'd0}; step("full", 2, row);
        row = '{4'b1111, 1'b0, 12'h0AB, 4'b0001, 1'b1, 16'h00AB, 5'd15, 1'b1, 2'd0}; step("full", 3, row);
        row = '{4'b1111, 1'b1, 12'h0AB, 4'b0000, 1'b0, 16'h00AB, 5'd16, 1'b1, 2'd0}; step("full", 4, row);
        row = '{4'b1111, 1'b0, 12'h0AB, 4'b0001, 1'b1, 16'h00AB, 5'd15, 1'b1, 2'd0}; step("full", 5, row);
        // Producer 0 withdraws while stalled: release, then producer 1 is next.
        row = '{4'b1110, 1'b0, 12'h0AB, 4'b0000, 1'b0, 16'h00AB, 5'd16, 1'b1, 2'd0}; step("full", 6, row);
        row = '{4'b1110, 1'b0, 12'h0AB, 4'b0000, 1'b0, 16'h00AB, 5'd16, 1'b0, 2'd0}; step("full", 7, row);
        row = '{4'b1110, 1'b0, 12'h0AB, 4'b0000, 1'b0, 16'h10AB, 5'd16, 1'b1, 2'd1}; step("full", 8, row);

        // Reset during the second word of a grant to producer 1.
        do_reset();
        row = '{4'b0010, 1'b0, 12'h300, 4'b0000, 1'b0, 16'h0300, 5'd0, 1'b0, 2'd0}; step("mid", 0, row);
        row = '{4'b0010, 1'b0, 12'h300, 4'b0010, 1'b1, 16'h1300, 5'd0, 1'b1, 2'd1}; step("mid", 1, row);
        drive(4'b0010, 1'b0, 12'h301);
        @(negedge clk);
        chk("mid.w_en2",  2, 32'(fifo_w_en), 32'h1);
        chk("mid.count2", 2, 32'(fifo_count), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("mid.rst_ready", 3, 32'(req_ready), 32'h0);
        chk("mid.rst_w_en",  3, 32'(fifo_w_en), 32'h0);
        chk("mid.rst_count", 3, 32'(fifo_count), 32'h0);
        chk("mid.rst_busy",  3, 32'(busy), 32'h0);
        drive(4'b0011, 1'b0, 12'h302);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        row = '{4'b0011, 1'b0, 12'h302, 4'b0001, 1'b1, 16'h0302, 5'd0, 1'b1, 2'd0}; step("mid", 4, row);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ producers. Each producer presents a valid/ready stream; the arbiter grants one producer at a time for a burst of up to MAX_BURST words and drives the FIFO write enable and data. The arbiter mirrors FIFO occupancy from its own writes and the observed read enable, and never issues a write the FIFO would drop.

## Interface
- NUM_REQ, 4: number of producers, 2..8.
- DATA_WIDTH, 16: word width; must equal the FIFO word width.
- FIFO_ENTRIES, 16: FIFO capacity in words.
- MAX_BURST, 4: maximum consecutive words per grant, at least 1.
- clk  input  1  clock; all logic on the rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-producer word valid.
- req_data  input  NUM_REQ*DATA_WIDTH  packed producer data; producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer ready; one-hot or zero.
- fifo_w_en  output  1  FIFO write enable.
- fifo_d_in  output  DATA_WIDTH  FIFO write data.
- fifo_r_en  input  1  the FIFO read enable, used for occupancy tracking.
- fifo_count  output  clog2(FIFO_ENTRIES+1)  mirrored occupancy.
- fifo_full  output  1  fifo_count == FIFO_ENTRIES.
- fifo_empty  output  1  fifo_count == 0.
- busy  output  1  state is GRANT.
- grant_id  output  clog2(NUM_REQ)  current or most recent granted producer.

## Operation
- States: IDLE and GRANT. Registers: state, grant_id, last_grant, burst_cnt, and count.
- IDLE: if any req_valid bit is set, select the first set bit searching from last_grant+1 upward, modulo NUM_REQ. Load grant_id and last_grant with that index, clear burst_cnt, and go to GRANT. Otherwise stay in IDLE.
- GRANT, readiness: req_ready[grant_id] = !fifo_full. All other ready bits are 0. Ready depends only on registers, never on req_valid.
- GRANT, handshake: a handshake occurs when req_valid[grant_id] and req_ready[grant_id] are both high.
  - fifo_w_en equals the handshake.
  - fifo_d_in is the req_data slice of grant_id, whatever the state of fifo_w_en.
- GRANT, release:
  - If req_valid[grant_id] is 0, return to IDLE with no transfer.
  - If a handshake occurs with burst_cnt == MAX_BURST-1, return to IDLE.
  - Otherwise, on a handshake, increment burst_cnt.
- GRANT, full stall: while fifo_full, the grant is held and burst_cnt holds. If the producer drops valid during the stall, the grant is released.
- Occupancy:
  - A read counts only if fifo_r_en and count != 0.
  - count increments on a write without a counted read.
  - count decrements on a counted read without a write.
  - count is unchanged when both occur or when neither occurs.
- fifo_r_en while count == 0 is ignored and count stays 0.
- A write is never issued while count == FIFO_ENTRIES, even with a simultaneous read. The FIFO evaluates full before the read takes effect.
- Fairness: after a grant to producer k, producer k has the lowest priority at the next arbitration.

## Timing
- Reset values: state IDLE, grant_id 0, last_grant NUM_REQ-1 (so producer 0 wins first), burst_cnt 0, count 0.
- Outputs in reset: req_ready 0, fifo_w_en 0, busy 0, fifo_full 0, fifo_empty 1. fifo_d_in shows the producer 0 slice.
- Arbitration latency: valid is seen in IDLE at edge n, and the first handshake is possible in cycle n+1.
- Every release costs exactly one IDLE bubble cycle before the next grant.
- A full uninterrupted burst of MAX_BURST words occupies MAX_BURST+1 cycles from the IDLE decision.
- fifo_count, fifo_full and fifo_empty are registered and update on the edge after the write or read.
- Reset mid-burst: all state clears immediately and asynchronously. The FIFO shares resetn, so the mirrored count and the FIFO's contents stay consistent.
- A word presented with valid in the same cycle that reset deasserts is not accepted until the next arbitration.

## Test plan
- Single producer: producer 2 holds valid with words 0xA000..0xA005 and MAX_BURST=4.
  - Required: grant in cycle 1; words A000..A003 written in cycles 1..4; IDLE in cycle 5.
  - Then A004..A005 written in cycles 6..7; fifo_count = 6.
- Round-robin: all four producers continuously valid after reset.
  - Required: grant order 0,1,2,3,0; each grant writes 4 words; exactly one bubble between grants.
- Full stall: no reads, one producer streams 20 words.
  - Required: count reaches 16; fifo_full = 1; ready low; the grant is held.
  - Then assert fifo_r_en for one cycle. Required: count drops to 15, then the next word is written and count returns to 16.
- Full with simultaneous read: at count 16, assert fifo_r_en while the producer is valid.
  - Required: no write that cycle; count goes to 15.
- Empty read: at count 0, pulse fifo_r_en for 3 cycles.
  - Required: count stays 0 and fifo_empty stays 1.
- Reset mid-burst: assert resetn low during the second word of a grant to producer 1.
  - Required: immediate req_ready 0, fifo_w_en 0, count 0.
  - After release, producer 0 is granted first if both are valid.
